// File: rtl/mult_pkg.sv
// Shared definitions for the sequential multiplier: FSM encoding and sizing helpers.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package mult_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Iteration counter width: $clog2(WIDTH), never narrower than one bit.
  function automatic int cnt_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/mult_abs_w.sv
// Conditional two's-complement negate of a W-bit value (magnitude / sign fix).
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
module mult_abs_w #(
  parameter int W = 3
) (
  input  logic         neg_in,
  input  logic [W-1:0] val_in,
  output logic [W-1:0] val_out
);

  // Invert-and-increment when negation is requested; the most negative value
  // maps onto itself, which read as unsigned is exactly its magnitude.
  assign val_out = neg_in ? (~val_in + W'(1)) : val_in;

endmodule

// File: rtl/seq_multiplier.sv
// Shift-add WIDTH x WIDTH multiplier (signed/unsigned per op), one adder reused per cycle.
// Latency: WIDTH CALC cycles + 1 DONE cycle after start is sampled (fewer with SEQ_MULT_EARLY_TERM_EN).
// Backpressure: start_in only accepted in IDLE/DONE; caller holds its operation until done_out.
module seq_multiplier #(
  parameter int WIDTH = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_in,
  input  logic               signed_in,
  input  logic [WIDTH-1:0]   a_in,
  input  logic [WIDTH-1:0]   b_in,
  output logic               busy_out,
  output logic               done_out,
  output logic [2*WIDTH-1:0] product_out
);

  import mult_pkg::*;

  localparam int PW    = 2 * WIDTH;
  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t            state;
  state_t            state_nxt;
  logic              sgn_r;
  logic              neg_r;
  logic [PW-1:0]     mcand;
  logic [PW-1:0]     acc;
  logic [PW-1:0]     acc_nxt;
  logic [PW-1:0]     prod_fix;
  logic [WIDTH-1:0]  mplier;
  logic [WIDTH-1:0]  mag_a;
  logic [WIDTH-1:0]  mag_b;
  logic [CNT_W-1:0]  cnt;
  logic              start_ok;
  logic              last_iter;

  // Operand magnitudes: only negate in signed mode with the sign bit set.
  mult_abs_w #(.W(WIDTH)) u_abs_a (
    .neg_in  (signed_in & a_in[WIDTH-1]),
    .val_in  (a_in),
    .val_out (mag_a)
  );

  mult_abs_w #(.W(WIDTH)) u_abs_b (
    .neg_in  (signed_in & b_in[WIDTH-1]),
    .val_in  (b_in),
    .val_out (mag_b)
  );

  // Result sign fix works on the accumulator value including this cycle's add,
  // so product_out can be captured on the same edge as the final iteration.
  mult_abs_w #(.W(PW)) u_fix (
    .neg_in  (sgn_r & neg_r),
    .val_in  (acc_nxt),
    .val_out (prod_fix)
  );

  assign start_ok = start_in & ((state == ST_IDLE) | (state == ST_DONE));
  assign acc_nxt  = mplier[0] ? (acc + mcand) : acc;

`ifdef SEQ_MULT_EARLY_TERM_EN
  // Stop as soon as no multiplier bits remain after this iteration.
  assign last_iter = (state == ST_CALC) & ((cnt == LAST_CNT) | ((mplier >> 1) == '0));
`else
  assign last_iter = (state == ST_CALC) & (cnt == LAST_CNT);
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode and status outputs derived from the current state.
  always_comb begin
    state_nxt = state;
    busy_out  = 1'b0;
    done_out  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start_in) state_nxt = ST_CALC;
      end
      ST_CALC: begin
        busy_out = 1'b1;
        if (last_iter) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        done_out  = 1'b1;
        state_nxt = start_in ? ST_CALC : ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Datapath: load on an accepted start, one shift-add step per CALC cycle,
  // and capture the sign-corrected product on the last step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sgn_r       <= 1'b0;
      neg_r       <= 1'b0;
      mcand       <= '0;
      mplier      <= '0;
      acc         <= '0;
      cnt         <= '0;
      product_out <= '0;
    end else if (start_ok) begin
      sgn_r  <= signed_in;
      neg_r  <= signed_in & (a_in[WIDTH-1] ^ b_in[WIDTH-1]);
      mcand  <= {{WIDTH{1'b0}}, mag_a};
      mplier <= mag_b;
      acc    <= '0;
      cnt    <= '0;
    end else if (state == ST_CALC) begin
      acc    <= acc_nxt;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + CNT_W'(1);
      if (last_iter) product_out <= prod_fix;
    end
  end

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed bench for seq_multiplier at WIDTH=3 and WIDTH=8.
// Latency: expected CALC length follows SEQ_MULT_EARLY_TERM_EN when defined.
// Backpressure: exercises start during CALC (ignored) and during DONE (back-to-back).
module tb_seq_multiplier;

`ifdef SEQ_MULT_EARLY_TERM_EN
  localparam bit ET = 1'b1;
`else
  localparam bit ET = 1'b0;
`endif

  typedef struct {
    logic        s;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] p;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        start3 = 1'b0, sgn3 = 1'b0;
  logic [2:0]  a3 = '0, b3 = '0;
  logic        busy3, done3;
  logic [5:0]  prod3;

  logic        start8 = 1'b0, sgn8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        busy8, done8;
  logic [15:0] prod8;

  int checks = 0;
  int errors = 0;

  seq_multiplier #(.WIDTH(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start_in(start3), .signed_in(sgn3),
    .a_in(a3), .b_in(b3), .busy_out(busy3), .done_out(done3), .product_out(prod3)
  );

  seq_multiplier #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start_in(start8), .signed_in(sgn8),
    .a_in(a8), .b_in(b8), .busy_out(busy8), .done_out(done8), .product_out(prod8)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected number of CALC cycles for an operation.
  function automatic int exp_calc(input int w, input logic s, input logic [7:0] b);
    logic [7:0] mask;
    logic [7:0] bb;
    logic [7:0] m;
    int hb;
    mask = (w == 3) ? 8'h07 : 8'hFF;
    bb = b & mask;
    m  = (s && bb[w-1]) ? ((~bb + 8'd1) & mask) : bb;
    hb = 0;
    for (int i = 0; i < w; i++) if (m[i]) hb = i;
    return ET ? hb + 1 : w;
  endfunction

  task automatic drive(input int w, input logic st, input logic s, input logic [7:0] a, input logic [7:0] b);
    if (w == 3) begin
      start3 = st; sgn3 = s; a3 = a[2:0]; b3 = b[2:0];
    end else begin
      start8 = st; sgn8 = s; a8 = a; b8 = b;
    end
  endtask

  // Called at a negedge: assert start for one cycle, then scramble the inputs
  // and count cycles until done_out. lat = -1 if done never arrives.
  task automatic run_op(input int w, input logic s, input logic [7:0] a, input logic [7:0] b,
                        output logic [15:0] prod, output int lat, output int bc);
    logic bz, dn;
    drive(w, 1'b1, s, a, b);
    lat = -1; bc = 0; prod = '0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1) drive(w, 1'b0, ~s, a ^ 8'h5A, b ^ 8'hA5);
      bz = (w == 3) ? busy3 : busy8;
      dn = (w == 3) ? done3 : done8;
      if (bz) bc++;
      if (dn) begin
        lat  = k;
        prod = (w == 3) ? {10'd0, prod3} : prod8;
        break;
      end
    end
  endtask

  task automatic run_table(input int w, input vec_t v, input int idx);
    logic [15:0] prod;
    int lat, bc, ec;
    ec = exp_calc(w, v.s, v.b);
    run_op(w, v.s, v.a, v.b, prod, lat, bc);
    chk($sformatf("w%0d_v%0d_prod", w, idx), 32'(prod), 32'(v.p));
    chk($sformatf("w%0d_v%0d_lat", w, idx), 32'(lat), 32'(ec + 1));
    chk($sformatf("w%0d_v%0d_busy", w, idx), 32'(bc), 32'(ec));
    @(negedge clk);
    chk($sformatf("w%0d_v%0d_done_pulse", w, idx), 32'((w == 3) ? done3 : done8), 32'd0);
    chk($sformatf("w%0d_v%0d_hold", w, idx), 32'((w == 3) ? {10'd0, prod3} : prod8), 32'(v.p));
  endtask

  vec_t t3[8];
  vec_t t8[6];

  initial begin
    logic [15:0] prod;
    int lat, bc, ndone;

    t3[0] = '{1'b0, 8'd7, 8'd7, 16'd49};
    t3[1] = '{1'b1, 8'd5, 8'd2, 16'd58};   // -3 * 2 = -6
    t3[2] = '{1'b1, 8'd4, 8'd4, 16'd16};   // -4 * -4
    t3[3] = '{1'b0, 8'd0, 8'd5, 16'd0};
    t3[4] = '{1'b1, 8'd7, 8'd3, 16'd61};   // -1 * 3 = -3
    t3[5] = '{1'b0, 8'd5, 8'd6, 16'd30};
    t3[6] = '{1'b1, 8'd3, 8'd3, 16'd9};
    t3[7] = '{1'b1, 8'd4, 8'd3, 16'd52};   // -4 * 3 = -12
    t8[0] = '{1'b1, 8'h80, 8'h80, 16'h4000};
    t8[1] = '{1'b0, 8'hFF, 8'hFF, 16'hFE01};
    t8[2] = '{1'b0, 8'hC8, 8'h01, 16'h00C8};
    t8[3] = '{1'b0, 8'h4D, 8'h00, 16'h0000};
    t8[4] = '{1'b0, 8'h03, 8'h80, 16'h0180};
    t8[5] = '{1'b1, 8'hFF, 8'h7F, 16'hFF81};

    // Reset state.
    repeat (2) @(negedge clk);
    chk("rst_busy3", 32'(busy3), 32'd0);
    chk("rst_done3", 32'(done3), 32'd0);
    chk("rst_prod3", 32'(prod3), 32'd0);
    chk("rst_prod8", 32'(prod8), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) run_table(3, t3[i], i);
    for (int i = 0; i < 6; i++) run_table(8, t8[i], i);

    // Start during CALC is ignored; start during DONE chains with no gap.
    drive(3, 1'b1, 1'b0, 8'd3, 8'd5);
    @(negedge clk); drive(3, 1'b0, 1'b0, 8'd0, 8'd0);
    @(negedge clk); drive(3, 1'b1, 1'b0, 8'd7, 8'd7);
    @(negedge clk); drive(3, 1'b0, 1'b1, 8'd6, 8'd6);
    chk("hs_busy_k3", 32'(busy3), 32'd1);
    @(negedge clk);
    chk("hs_done1", 32'(done3), 32'd1);
    chk("hs_prod1", 32'(prod3), 32'd15);
    run_op(3, 1'b0, 8'd2, 8'd3, prod, lat, bc);
    chk("hs_prod2", 32'(prod), 32'd6);
    chk("hs_lat2", 32'(lat), 32'(exp_calc(3, 1'b0, 8'd3) + 1));
    chk("hs_busy2", 32'(bc), 32'(exp_calc(3, 1'b0, 8'd3)));
    @(negedge clk);

    // Reset during the second CALC cycle aborts the operation.
    drive(3, 1'b1, 1'b0, 8'd7, 8'd7);
    @(negedge clk); drive(3, 1'b0, 1'b0, 8'd0, 8'd0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy3), 32'd0);
    chk("abort_done", 32'(done3), 32'd0);
    chk("abort_prod", 32'(prod3), 32'd0);
    ndone = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (done3) ndone++;
    end
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (done3) ndone++;
    end
    chk("abort_no_done", 32'(ndone), 32'd0);
    run_op(3, 1'b1, 8'd6, 8'd3, prod, lat, bc);  // -2 * 3 = -6
    chk("post_rst_prod", 32'(prod), 32'd58);
    chk("post_rst_lat", 32'(lat), 32'(exp_calc(3, 1'b1, 8'd3) + 1));
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
